// File: rtl/sync_frame_tx.sv
// ---------------------------------------------------------------------------
// sync_frame_tx
//
// Serial frame transmitter that feeds the Moore sync-word detector. A start
// request latches a parallel payload word. The block then emits one bit per
// clock: the sync pattern (MSB first), the payload (MSB first), and a run of
// guard zeros. The guard zeros put the detector back into its idle state.
//
// Ports:
//   clk_i        system clock, rising-edge active
//   rst_ni       asynchronous active-low reset (0 = reset)
//   start_i      frame request, only looked at while ready_o = 1
//   data_in_i    payload word, captured on the accepting edge
//   ready_o      high in IDLE; a start on this cycle is accepted
//   out_o        serial bit, decoded from registered state only
//   out_valid_o  high while out_o carries a sync or payload bit
//   busy_o       high during SYNC, DATA and GUARD
//   done_o       one-cycle pulse on the first IDLE cycle after GUARD
// ---------------------------------------------------------------------------
module sync_frame_tx #(
    parameter int                SYNC_W    = 5,
    parameter logic [SYNC_W-1:0] SYNC_PAT  = 5'b10101,
    parameter int                DATA_W    = 8,
    parameter int                GUARD_LEN = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic              ready_o,
    output logic              out_o,
    output logic              out_valid_o,
    output logic              busy_o,
    output logic              done_o
);

    // One down-counter is shared by every phase, so it is sized for the
    // longest of them. Each phase loads length-1 and leaves at zero, so the
    // counter never has to hold the full length and never wraps.
    localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX_LEN = (MAX_SD > GUARD_LEN) ? MAX_SD : GUARD_LEN;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] SYNC_LOAD  = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LOAD  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SYNC  = 2'b01,
        DATA  = 2'b10,
        GUARD = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              done_q,  done_d;

    // State, counter, payload shift register and done flag. The reset is
    // asynchronous so a mid-frame reset silences the line before the next edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. A start is only honoured in IDLE, so requests made
    // while a frame is in flight are dropped rather than queued. done_d is
    // raised on the last GUARD edge, which makes done_q high for exactly the
    // first IDLE cycle. That cycle is also a ready cycle, so a start held
    // high chains frames with only the done cycle between them.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shreg_d = data_in_i;
                    cnt_d   = SYNC_LOAD;
                    state_d = SYNC;
                end
            end

            SYNC: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = DATA_LOAD;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            DATA: begin
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = GUARD_LOAD;
                    state_d = GUARD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            GUARD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. Only registered values are used here, so start_i and
    // data_in_i have no path to any output. During SYNC the counter doubles
    // as the pattern bit index. It counts down, so the MSB goes out first.
    always_comb begin
        out_o       = 1'b0;
        out_valid_o = 1'b0;

        case (state_q)
            SYNC: begin
                out_o       = SYNC_PAT[cnt_q];
                out_valid_o = 1'b1;
            end
            DATA: begin
                out_o       = shreg_q[DATA_W-1];
                out_valid_o = 1'b1;
            end
            default: begin
                out_o       = 1'b0;
                out_valid_o = 1'b0;
            end
        endcase
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_sync_frame_tx
//
// Directed testbench for sync_frame_tx with the default parameters
// (sync 10101, 8-bit payload, 2 guard zeros, 15-cycle frames). Inputs change
// and outputs are sampled on the falling clock edge, away from the active
// edge. A behavioural Moore sync-word detector watches the serial line.
// ---------------------------------------------------------------------------
module tb_sync_frame_tx;

    logic       clk;
    logic       rstN;
    logic       start;
    logic [7:0] dataIn;
    logic       ready;
    logic       serOut;
    logic       outValid;
    logic       busy;
    logic       done;

    int vectorCount = 0;
    int missCount   = 0;

    logic [4:0] syncPat = 5'b10101;

    // Behavioural detector model: a 5-bit history of the line. Its Moore
    // output is high while the history equals the sync word.
    logic [4:0] detHist = '0;
    logic       detPrev = 1'b0;
    int         detRises = 0;
    logic       detOut;

    assign detOut = (detHist == 5'b10101);

    sync_frame_tx dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .start_i     (start),
        .data_in_i   (dataIn),
        .ready_o     (ready),
        .out_o       (serOut),
        .out_valid_o (outValid),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The detector shifts in the serial bit on every rising edge and counts
    // the rising edges of its own output.
    always @(posedge clk) begin
        detHist <= {detHist[3:0], serOut};
        detPrev <= detOut;
        if (detOut && !detPrev) detRises <= detRises + 1;
    end

    // Watchdog so that the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] d);
        start  = s;
        dataIn = d;
    endtask

    // Call this after the accepting edge has been set up, with inputs
    // already driven for that edge. The task checks frame cycles 1..15 and
    // then the done cycle 16. After checking cycle i it drives the inputs
    // for the edge that ends cycle i. There are three cases:
    //   keepStart  : start stays 1 with keepData
    //   pokeCycle  : start=1 with data 00 on that one cycle (must be ignored)
    //   otherwise  : start=0
    task automatic runFrame(input string tag, input logic [7:0] expData,
                            input bit keepStart, input logic [7:0] keepData,
                            input int pokeCycle);
        logic expOut;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i <= 5)       expOut = syncPat[5-i];
            else if (i <= 13) expOut = expData[13-i];
            else              expOut = 1'b0;
            checkOutput($sformatf("%s out c%0d", tag, i), 32'(serOut), 32'(expOut));
            checkOutput($sformatf("%s valid c%0d", tag, i), 32'(outValid), 32'(i <= 13));
            checkOutput($sformatf("%s busy c%0d", tag, i), 32'(busy), 32'd1);
            checkOutput($sformatf("%s ready c%0d", tag, i), 32'(ready), 32'd0);
            checkOutput($sformatf("%s done c%0d", tag, i), 32'(done), 32'd0);
            if (keepStart)           applyStimulus(1'b1, keepData);
            else if (i == pokeCycle) applyStimulus(1'b1, 8'h00);
            else                     applyStimulus(1'b0, 8'h00);
        end
        @(negedge clk);
        checkOutput({tag, " done c16"}, 32'(done), 32'd1);
        checkOutput({tag, " ready c16"}, 32'(ready), 32'd1);
        checkOutput({tag, " busy c16"}, 32'(busy), 32'd0);
        checkOutput({tag, " out c16"}, 32'(serOut), 32'd0);
        checkOutput({tag, " valid c16"}, 32'(outValid), 32'd0);
        if (keepStart) applyStimulus(1'b1, keepData);
        else           applyStimulus(1'b0, 8'h00);
    endtask

    initial begin
        $display("[TB] sync_frame_tx directed test starting");
        rstN = 1'b0;
        applyStimulus(1'b1, 8'hA5);

        // 1. Reset held with start high: outputs stay idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst out", 32'(serOut), 32'd0);
            checkOutput("rst valid", 32'(outValid), 32'd0);
            checkOutput("rst busy", 32'(busy), 32'd0);
            checkOutput("rst ready", 32'(ready), 32'd1);
            checkOutput("rst done", 32'(done), 32'd0);
        end
        rstN = 1'b1;
        applyStimulus(1'b0, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("idle busy", 32'(busy), 32'd0);
            checkOutput("idle ready", 32'(ready), 32'd1);
            checkOutput("idle done", 32'(done), 32'd0);
        end

        // 2. Single frame with A5.
        applyStimulus(1'b1, 8'hA5);
        runFrame("single", 8'hA5, 1'b0, 8'h00, -1);
        @(negedge clk);
        checkOutput("single done drop", 32'(done), 32'd0);

        // 3. Start while busy is ignored: payload FF survives a poke on cycle 4.
        applyStimulus(1'b1, 8'hFF);
        runFrame("busyreq", 8'hFF, 1'b0, 8'h00, 4);
        @(negedge clk);
        checkOutput("busyreq no requeue busy", 32'(busy), 32'd0);
        checkOutput("busyreq single done", 32'(done), 32'd0);

        // 4. Back-to-back frames with start held high.
        applyStimulus(1'b1, 8'h3C);
        runFrame("b2b f1", 8'h3C, 1'b1, 8'h3C, -1);
        runFrame("b2b f2", 8'h3C, 1'b1, 8'h3C, -1);
        runFrame("b2b f3", 8'h3C, 1'b0, 8'h00, -1);
        @(negedge clk);
        checkOutput("b2b end idle", 32'(busy), 32'd0);

        // 5. Asynchronous reset during payload bit 3 (frame cycle 9).
        applyStimulus(1'b1, 8'hFF);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00);
        for (int i = 2; i <= 9; i++) @(negedge clk);
        checkOutput("midrst pre out", 32'(serOut), 32'd1);
        checkOutput("midrst pre busy", 32'(busy), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midrst out", 32'(serOut), 32'd0);
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst valid", 32'(outValid), 32'd0);
        checkOutput("midrst ready", 32'(ready), 32'd1);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("postrst idle", 32'(ready), 32'd1);
        applyStimulus(1'b1, 8'h5A);
        runFrame("postrst", 8'h5A, 1'b0, 8'h00, -1);

        // 6. Loopback into the detector with a zero payload: one rise per frame.
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            detRises = 0;
            applyStimulus(1'b1, 8'h00);
            @(negedge clk);
            applyStimulus(1'b0, 8'h00);
            for (int i = 1; i <= 5; i++) @(negedge clk);
            checkOutput($sformatf("loop f%0d det after sync", f), 32'(detOut), 32'd1);
            for (int i = 6; i <= 17; i++) @(negedge clk);
            checkOutput($sformatf("loop f%0d rises", f), 32'(detRises), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
